// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - byte-stream to wishbone ROM backdoor programmer
// Streams bytes into consecutive ROM addresses, holding the CPU in reset while loading.
module rom_loader #(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic [31:0]           wb_addr_o,
    output logic [31:0]           wb_data_o,
    output logic                  wb_cyc_o,
    output logic                  wb_strobe_o,
    output logic                  wb_we_o,
    input  logic                  wb_ack_i,
    output logic                  cpu_reset_o,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_BYTE = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] DONE      = 3'd3;
    localparam logic [2:0] ERR       = 3'd4;

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [31:0]           wb_addr_q, wb_addr_d;
    logic [31:0]           wb_data_q, wb_data_d;
    logic                  bus_q, bus_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        timer_d     = timer_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        bus_d       = bus_q;
        cpu_rst_d   = cpu_rst_q;
        done_d      = done_q;
        error_d     = error_q;

        // Abort overrides everything, including a simultaneous start or ack.
        if (abort) begin
            state_d   = IDLE;
            bus_d     = 1'b0;
            cpu_rst_d = 1'b0;
            done_d    = 1'b0;
            error_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        cur_addr_d  = base_addr;
                        remaining_d = length;
                        count_d     = '0;
                        done_d      = 1'b0;
                        error_d     = 1'b0;
                        if (length != '0) begin
                            state_d   = WAIT_BYTE;
                            cpu_rst_d = 1'b1;
                        end else begin
                            state_d   = DONE;
                            done_d    = 1'b1;
                            cpu_rst_d = 1'b0;
                        end
                    end
                end
                WAIT_BYTE: begin
                    if (byte_valid) begin
                        state_d   = WRITE;
                        bus_d     = 1'b1;
                        wb_addr_d = {{(32-ADDR_WIDTH){1'b0}}, cur_addr_q};
                        wb_data_d = {24'b0, byte_data};
                        timer_d   = '0;
                    end
                end
                WRITE: begin
                    // A same-cycle ack beats the timeout.
                    if (wb_ack_i) begin
                        bus_d       = 1'b0;
                        cur_addr_d  = cur_addr_q + 1'b1;
                        count_d     = count_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
                            state_d   = DONE;
                            done_d    = 1'b1;
                            cpu_rst_d = 1'b0;
                        end else begin
                            state_d = WAIT_BYTE;
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        bus_d   = 1'b0;
                        state_d = ERR;
                        error_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            bus_q       <= 1'b0;
            cpu_rst_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            bus_q       <= bus_d;
            cpu_rst_q   <= cpu_rst_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign byte_ready  = (state_q == WAIT_BYTE);
    assign busy        = (state_q == WAIT_BYTE) || (state_q == WRITE);
    assign wb_addr_o   = wb_addr_q;
    assign wb_data_o   = wb_data_q;
    assign wb_cyc_o    = bus_q;
    assign wb_strobe_o = bus_q;
    assign wb_we_o     = bus_q;
    assign cpu_reset_o = cpu_rst_q;
    assign done        = done_q;
    assign error       = error_q;
    assign count       = count_q;

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
Sequencer that bulk-programs the program ROM through its wishbone backdoor write port. It accepts a byte stream over a valid/ready interface from a host-side source (UART bridge or test harness) and issues one single-beat wishbone write per byte at auto-incrementing addresses. While a load is in progress it holds the CPU core in reset. It tolerates the ROM acking only once per 8-clock bus frame, and flags an error if an ack never arrives.

Parameters:
ADDR_WIDTH, 12, ROM byte-address width; addresses wrap modulo 2^ADDR_WIDTH.
TIMEOUT_CYCLES, 32, clocks to wait for wb_ack_i per write before error; must be >= 10.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-clock pulse; begins a load
abort  input  1  one-clock pulse; cancels any activity and returns to IDLE
base_addr  input  ADDR_WIDTH  first ROM address, sampled on accepted start
length  input  ADDR_WIDTH+1  number of bytes, 0..2^ADDR_WIDTH, sampled on accepted start
byte_valid  input  1  stream byte available
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this clock
wb_addr_o  output  32  {zero-extend, current address}
wb_data_o  output  32  {24'b0, captured byte}
wb_cyc_o  output  1  wishbone cycle
wb_strobe_o  output  1  wishbone strobe
wb_we_o  output  1  write enable
wb_ack_i  input  1  wishbone ack from ROM
cpu_reset_o  output  1  holds CPU in reset during a load and after an error
busy  output  1  load in progress
done  output  1  last load completed successfully (level)
error  output  1  last load timed out (level)
count  output  ADDR_WIDTH+1  bytes written in the current or last load

Behaviour:
- States: IDLE, WAIT_BYTE, WRITE, DONE, ERR. All outputs are registered except byte_ready (= state==WAIT_BYTE) and busy (= WAIT_BYTE or WRITE).
- Reset (async): state IDLE; wb_cyc_o/strobe/we = 0; wb_addr_o = 0; wb_data_o = 0; cpu_reset_o = 0; done = 0; error = 0; count = 0; timer = 0.
- start accepted only in IDLE, DONE or ERR; ignored while busy. On an accepted start: latch cur_addr = base_addr and remaining = length; clear count, done and error.
  - If length != 0: go to WAIT_BYTE and set cpu_reset_o = 1.
  - If length == 0: go to DONE with cpu_reset_o = 0.
- WAIT_BYTE: on byte_valid && byte_ready, capture byte_data, go to WRITE, and assert wb_cyc_o/strobe/we (all 1) from the next clock. wb_addr_o = cur_addr; wb_data_o = byte. Clear timer.
- WRITE: hold all wishbone outputs stable; timer increments each clock.
  - When wb_ack_i is sampled high: deassert cyc/strobe/we on that edge; cur_addr += 1 (wraps); count += 1; remaining -= 1. Next state is DONE if remaining was 1, else WAIT_BYTE. Result: minimum 2 clocks per byte plus ROM ack latency (<= 8 clocks).
  - Timeout: if timer reaches TIMEOUT_CYCLES-1 with no ack, deassert the bus and go to ERR. An ack on the same clock as the timeout takes priority (the write succeeds).
- DONE: done = 1, cpu_reset_o = 0; held until the next start.
- ERR: error = 1 and cpu_reset_o stays 1 (CPU must not run a partial image); held until start or abort.
- abort: from any state, go to IDLE next clock; drop cyc/strobe/we; cpu_reset_o = 0; done = error = 0; count is retained.
  - abort and start on the same clock: abort wins, start is ignored.
  - A late ack after an abort or timeout is ignored.
- wb_ack_i outside WRITE is ignored. byte_valid outside WAIT_BYTE is not consumed.
- Address wrap: base_addr = 0xFFE with length 4 writes 0xFFE, 0xFFF, 0x000, 0x001.

Test Plan:
- Basic load: base 0x010, length 3, bytes A5/5A/3C with ROM model acking at frame cycle 7 -> three writes at 0x010..0x012 with correct data; count = 3; done = 1; cpu_reset_o 1 during the load and 0 after; ROM read-back matches.
- Backpressured stream: byte_valid toggling randomly, length 16 -> exactly 16 writes in order, no byte dropped or duplicated; byte_ready is 0 while WRITE is pending.
- Wrap and zero length: base 0xFFE, length 4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001. Then start with length 0 -> DONE on the next clock with no wishbone activity and count = 0.
- Timeout: ack tied low, length 2 -> bus held TIMEOUT_CYCLES clocks, then dropped; error = 1; cpu_reset_o = 1; count = 0. A subsequent start with a working ROM clears error and completes.
- Abort mid-write: abort while wb_cyc_o = 1, with an ack arriving 2 clocks later -> IDLE, bus low on the next clock; the late ack causes no count change; cpu_reset_o = 0.
- Reset mid-load: assert reset asynchronously during WRITE -> all outputs reach their reset values immediately with no clock edge; a start issued while busy earlier in the test was ignored.
